hazard3_timer_apb_arbiter: RTL and testbench

Two-hart APB arbiter that shares the single 32-bit APB slave port of the RISC-V machine timer (mtime/mtimecmp/IPI registers) between hart 0 and hart 1. It sits between the per-hart peripheral APB outputs and the timer. It serialises accesses with round-robin fairness and tags each forwarded transfer with the issuing hart's ID and PC. It also shapes the handshake so the timer sees clean, non-overlapping transfers that return to idle between accesses.

---
 rtl/hazard3_timer_apb_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_hazard3_timer_apb_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_timer_apb_arbiter.sv
// Two-hart round-robin APB arbiter in front of the machine-timer slave port.
// Each forwarded transfer carries the granted hart ID and PC; idle gaps separate transfers.
module hazard3_timer_apb_arbiter #(
    parameter int W_DATA  = 32,
    parameter int W_ADDR  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         s_paddr,
    input  logic [1:0]          s_psel,
    input  logic [1:0]          s_penable,
    input  logic [1:0]          s_pwrite,
    input  logic [63:0]         s_pwdata,
    input  logic [2*W_ADDR-1:0] s_pc,
    output logic [63:0]         s_prdata,
    output logic [1:0]          s_pready,
    output logic [1:0]          s_pslverr,
    output logic [15:0]         m_paddr,
    output logic                m_psel,
    output logic                m_penable,
    output logic                m_pwrite,
    output logic [31:0]         m_pwdata,
    output logic [W_DATA-1:0]   m_phartid,
    output logic [W_ADDR-1:0]   m_pd_pc,
    input  logic [31:0]         m_prdata,
    input  logic                m_pready,
    input  logic                m_pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_ACCESS   = 2'd2,
        ST_COMPLETE = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t              state_r, state_s;
    logic                grant_r, grant_s, last_r, last_s, req_grant_s;
    logic [7:0]          cnt_r, cnt_s;
    logic [15:0]         paddr_r, paddr_s, req_addr_s;
    logic                pwrite_r, pwrite_s, psel_r, psel_s, penable_r, penable_s;
    logic [31:0]         pwdata_r, pwdata_s;
    logic [W_ADDR-1:0]   pc_r, pc_s;
    logic [63:0]         prdata_r, prdata_s;
    logic [1:0]          pready_r, pready_s, pslverr_r, pslverr_s;
    logic                unused_s;

    // Both pending: the hart that did not win last time; otherwise the only requester.
    function automatic logic pick_grant(input logic [1:0] req, input logic last);
        logic g;
        if (req == 2'b11) begin
            g = ~last;
        end else begin
            g = req[1];
        end
        return g;
    endfunction

    function automatic logic [63:0] merge_rdata(input logic [63:0] old, input logic idx,
                                                input logic [31:0] val);
        logic [63:0] r;
        if (idx) begin
            r = {val, old[31:0]};
        end else begin
            r = {old[63:32], val};
        end
        return r;
    endfunction

    assign unused_s   = ^s_penable;
    assign req_grant_s = pick_grant(s_psel, last_r);
    assign req_addr_s  = req_grant_s ? s_paddr[31:16] : s_paddr[15:0];

    // Next-state and next-output computation; outputs are registered from these values.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        last_s    = last_r;
        cnt_s     = cnt_r;
        paddr_s   = paddr_r;
        pwrite_s  = pwrite_r;
        pwdata_s  = pwdata_r;
        pc_s      = pc_r;
        prdata_s  = prdata_r;
        pready_s  = 2'b00;
        pslverr_s = 2'b00;
        psel_s    = 1'b0;
        penable_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (s_psel != 2'b00) begin
                    grant_s  = req_grant_s;
                    last_s   = req_grant_s;
                    paddr_s  = req_addr_s;
                    pwrite_s = s_pwrite[req_grant_s];
                    pwdata_s = req_grant_s ? s_pwdata[63:32] : s_pwdata[31:0];
                    pc_s     = req_grant_s ? s_pc[2*W_ADDR-1:W_ADDR] : s_pc[W_ADDR-1:0];
                    // Misaligned requests are answered locally and never reach the timer.
                    if (req_addr_s[1:0] != 2'b00) begin
                        state_s                = ST_COMPLETE;
                        pready_s[req_grant_s]  = 1'b1;
                        pslverr_s[req_grant_s] = 1'b1;
                        prdata_s               = merge_rdata(prdata_r, req_grant_s, 32'd0);
                    end else begin
                        state_s = ST_SETUP;
                        psel_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s   = ST_ACCESS;
                cnt_s     = 8'd0;
                psel_s    = 1'b1;
                penable_s = 1'b1;
            end
            ST_ACCESS: begin
                if (m_pready) begin
                    state_s            = ST_COMPLETE;
                    pready_s[grant_r]  = 1'b1;
                    pslverr_s[grant_r] = m_pslverr;
                    prdata_s           = merge_rdata(prdata_r, grant_r, m_prdata);
                end else if (cnt_r == TO_LAST) begin
                    state_s            = ST_COMPLETE;
                    pready_s[grant_r]  = 1'b1;
                    pslverr_s[grant_r] = 1'b1;
                    prdata_s           = merge_rdata(prdata_r, grant_r, 32'd0);
                end else begin
                    cnt_s     = cnt_r + 8'd1;
                    psel_s    = 1'b1;
                    penable_s = 1'b1;
                end
            end
            ST_COMPLETE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; hart 0 wins the first contended grant after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            grant_r   <= 1'b0;
            last_r    <= 1'b1;
            cnt_r     <= 8'd0;
            paddr_r   <= 16'd0;
            pwrite_r  <= 1'b0;
            pwdata_r  <= 32'd0;
            pc_r      <= '0;
            prdata_r  <= 64'd0;
            pready_r  <= 2'b00;
            pslverr_r <= 2'b00;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            last_r    <= last_s;
            cnt_r     <= cnt_s;
            paddr_r   <= paddr_s;
            pwrite_r  <= pwrite_s;
            pwdata_r  <= pwdata_s;
            pc_r      <= pc_s;
            prdata_r  <= prdata_s;
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
        end
    end

    assign s_prdata  = prdata_r;
    assign s_pready  = pready_r;
    assign s_pslverr = pslverr_r;
    assign m_paddr   = paddr_r;
    assign m_psel    = psel_r;
    assign m_penable = penable_r;
    assign m_pwrite  = pwrite_r;
    assign m_pwdata  = pwdata_r;
    assign m_phartid = {{(W_DATA-1){1'b0}}, grant_r};
    assign m_pd_pc   = pc_r;

endmodule

// File: tb/tb_hazard3_timer_apb_arbiter.sv
// Bench for the two-hart timer APB arbiter: directed scenarios plus random traffic
// checked against a transaction-level timing model of the arbiter.
module tb_hazard3_timer_apb_arbiter;
    localparam int W_DATA  = 32;
    localparam int W_ADDR  = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] s_paddr;
    logic [1:0]  s_psel, s_penable, s_pwrite, s_pready, s_pslverr;
    logic [63:0] s_pwdata, s_pc, s_prdata;
    logic [15:0] m_paddr;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_pslverr;
    logic [31:0] m_pwdata, m_prdata;
    logic [W_DATA-1:0] m_phartid;
    logic [W_ADDR-1:0] m_pd_pc;

    int tests_run = 0;
    int tests_failed = 0;
    bit model_last = 1'b1;
    logic [31:0] exp_rd0 = 32'd0, exp_rd1 = 32'd0;
    int w_cur = 1;
    int acc_idx = 0;
    txn_t q0[$], q1[$];
    bit glog[$];

    hazard3_timer_apb_arbiter #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_pwdata(s_pwdata), .s_pc(s_pc), .s_prdata(s_prdata), .s_pready(s_pready),
        .s_pslverr(s_pslverr), .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_phartid(m_phartid), .m_pd_pc(m_pd_pc),
        .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tmr_data(input logic [15:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    function automatic logic tmr_err(input logic [15:0] a);
        return a[15:12] == 4'hE;
    endfunction

    function automatic txn_t rand_txn(input int mis_pct);
        txn_t t;
        t.addr = 16'($urandom);
        if (int'($urandom_range(0, 99)) < mis_pct) begin
            if (t.addr[1:0] == 2'b00) t.addr[1:0] = 2'b01;
        end else begin
            t.addr[1:0] = 2'b00;
        end
        t.wr = 1'($urandom);
        t.wdata = $urandom;
        t.pc = $urandom;
        return t;
    endfunction

    // Timer slave: answers w_cur ACCESS cycles after access starts.
    task automatic timer_drive();
        if (m_psel && m_penable) begin
            m_pready = (acc_idx == w_cur);
            m_prdata = m_pready ? tmr_data(m_paddr) : $urandom;
            m_pslverr = m_pready ? tmr_err(m_paddr) : 1'($urandom);
            acc_idx++;
        end else begin
            m_pready = 1'b0;
            m_prdata = $urandom;
            m_pslverr = 1'b0;
            acc_idx = 0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_psel = 2'b00; s_penable = 2'b00; s_paddr = 32'd0; s_pwrite = 2'b00;
        s_pwdata = 64'd0; s_pc = 64'd0;
        m_pready = 1'b0; m_prdata = 32'd0; m_pslverr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1; exp_rd0 = 32'd0; exp_rd1 = 32'd0; acc_idx = 0;
    endtask

    // Drives q0/q1 through the DUT and checks every cycle against the timing model.
    task automatic engine(input int max_cyc, input int gap_max, input int w_lo, input int w_hi,
                          input bit drop_en);
        txn_t cur [2];
        txn_t gt;
        bit act [2];
        bit dropped [2];
        int gap [2];
        bit busy = 1'b0, gh = 1'b0, gmis = 1'b0;
        int g_cyc = 0, done_cyc = 0, free_from = 0, k = 0, w_eff = 0;
        logic exp_psel, exp_pen, eerr;
        logic [1:0] exp_rdy, exp_err;
        logic [31:0] dval;
        for (int h = 0; h < 2; h++) begin
            cur[h] = '{16'd0, 1'b0, 32'd0, 32'd0};
            act[h] = 1'b0; dropped[h] = 1'b0; gap[h] = 0;
        end
        gt = cur[0];
        glog.delete();
        while (busy || act[0] || act[1] || q0.size() != 0 || q1.size() != 0) begin
            if (k >= max_cyc) begin
                tests_run++; tests_failed++;
                $display("FAIL engine_budget: got %0d cycles without finishing, required < %0d", k, max_cyc);
                break;
            end
            @(negedge clk);
            timer_drive();
            exp_psel = busy && !gmis && k > g_cyc && k < done_cyc;
            exp_pen  = busy && !gmis && k > g_cyc + 1 && k < done_cyc;
            tests_run++;
            if (m_psel !== exp_psel || m_penable !== exp_pen) begin
                tests_failed++;
                $display("FAIL m_psel_penable k=%0d: got %b%b required %b%b", k, m_psel, m_penable, exp_psel, exp_pen);
            end
            if (exp_psel && k == g_cyc + 1) begin
                glog.push_back(m_phartid[0]);
                tests_run++;
                if ({m_phartid, m_paddr, m_pwrite, m_pwdata, m_pd_pc} !==
                    {{(W_DATA-1){1'b0}}, gh, gt.addr, gt.wr, gt.wdata, gt.pc}) begin
                    tests_failed++;
                    $display("FAIL setup_fields k=%0d: got hart %0d addr %h wr %b wdata %h pc %h required hart %0d addr %h wr %b wdata %h pc %h",
                             k, m_phartid, m_paddr, m_pwrite, m_pwdata, m_pd_pc, gh, gt.addr, gt.wr, gt.wdata, gt.pc);
                end
            end
            exp_rdy = 2'b00; exp_err = 2'b00;
            if (busy && k == done_cyc) begin
                if (gmis || w_eff >= TIMEOUT) begin
                    dval = 32'd0; eerr = 1'b1;
                end else begin
                    dval = tmr_data(gt.addr); eerr = tmr_err(gt.addr);
                end
                exp_rdy[gh] = 1'b1; exp_err[gh] = eerr;
                if (gh) exp_rd1 = dval; else exp_rd0 = dval;
            end
            tests_run++;
            if (s_pready !== exp_rdy || s_pslverr !== exp_err || s_prdata !== {exp_rd1, exp_rd0}) begin
                tests_failed++;
                $display("FAIL response k=%0d: got rdy %b err %b rdata %h required rdy %b err %b rdata %h",
                         k, s_pready, s_pslverr, s_prdata, exp_rdy, exp_err, {exp_rd1, exp_rd0});
            end
            if (busy && k == done_cyc) begin
                busy = 1'b0; free_from = k + 1;
                act[gh] = 1'b0; dropped[gh] = 1'b0;
                gap[gh] = $urandom_range(0, gap_max);
            end
            for (int h = 0; h < 2; h++) begin
                if (!act[h]) begin
                    if (gap[h] > 0) gap[h]--;
                    else if (h == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); act[0] = 1'b1; end
                    else if (h == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); act[1] = 1'b1; end
                end
                if (drop_en && busy && gh == h[0] && !gmis && k > g_cyc && $urandom_range(0, 3) == 0)
                    dropped[h] = 1'b1;
            end
            s_psel    = {act[1] && !dropped[1], act[0] && !dropped[0]};
            s_penable = s_psel;
            s_paddr   = {cur[1].addr, cur[0].addr};
            s_pwrite  = {cur[1].wr, cur[0].wr};
            s_pwdata  = {cur[1].wdata, cur[0].wdata};
            s_pc      = {cur[1].pc, cur[0].pc};
            if (!busy && k >= free_from && s_psel != 2'b00) begin
                gh = (s_psel == 2'b11) ? !model_last : s_psel[1];
                model_last = gh;
                gt = cur[gh];
                gmis = (gt.addr[1:0] != 2'b00);
                w_cur = $urandom_range(w_lo, w_hi);
                w_eff = w_cur;
                g_cyc = k;
                done_cyc = gmis ? k + 1 : k + 3 + ((w_eff < TIMEOUT) ? w_eff : TIMEOUT - 1);
                busy = 1'b1;
            end
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_phartid, m_pd_pc} !== '0) begin
            tests_failed++;
            $display("FAIL reset_master: got psel %b addr %h hartid %h, required all zero", m_psel, m_paddr, m_phartid);
        end
        tests_run++;
        if ({s_prdata, s_pready, s_pslverr} !== '0) begin
            tests_failed++;
            $display("FAIL reset_slave: got rdy %b err %b rdata %h, required all zero", s_pready, s_pslverr, s_prdata);
        end
        do_reset();
        @(negedge clk);
        tests_run++;
        if ({m_psel, m_penable, m_phartid, s_pready, s_pslverr, s_prdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got psel %b rdy %b, required idle zeros", m_psel, s_pready);
        end
    endtask

    task automatic test_contention();
        txn_t t;
        do_reset();
        t = rand_txn(0); t.addr = 16'h0010; t.wr = 1'b1; q0.push_back(t);
        t = rand_txn(0); t.addr = 16'h0018; t.wr = 1'b1; q1.push_back(t);
        engine(100, 0, 1, 1, 1'b0);
        tests_run++;
        if (glog.size() != 2 || glog[0] !== 1'b0 || glog[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL contention_order: got %0d grants first %0d, required 2 grants order 0,1",
                     glog.size(), (glog.size() > 0) ? int'(glog[0]) : -1);
        end
    endtask

    task automatic test_single_read();
        logic [5:0] e_psel, e_pen;
        logic [1:0] e_rdy;
        e_psel = 6'b001110;
        e_pen  = 6'b001100;
        @(negedge clk);
        s_psel = 2'b01; s_penable = 2'b00; s_pwrite = 2'b00;
        s_paddr = {16'h0044, 16'h0008}; s_pc = {32'h0000_2000, 32'h0000_1004};
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            m_pready  = (c == 3);
            m_prdata  = (c == 3) ? 32'h1234_5678 : $urandom;
            m_pslverr = 1'b0;
            s_penable = (c >= 1 && c < 4) ? 2'b01 : 2'b00;
            e_rdy = (c == 4) ? 2'b01 : 2'b00;
            tests_run++;
            if (m_psel !== e_psel[c] || m_penable !== e_pen[c] || s_pready !== e_rdy) begin
                tests_failed++;
                $display("FAIL single_read_timing c=%0d: got psel %b pen %b rdy %b required %b %b %b",
                         c, m_psel, m_penable, s_pready, e_psel[c], e_pen[c], e_rdy);
            end
            if (c == 1) begin
                tests_run++;
                if (m_phartid !== 32'd0 || m_paddr !== 16'h0008 || m_pwrite !== 1'b0 || m_pd_pc !== 32'h0000_1004) begin
                    tests_failed++;
                    $display("FAIL single_read_setup: got hart %h addr %h pc %h required 0 0008 00001004", m_phartid, m_paddr, m_pd_pc);
                end
            end
            if (c == 4) begin
                tests_run++;
                if (s_prdata !== {exp_rd1, 32'h1234_5678} || s_pslverr !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL single_read_data: got %h err %b required %h err 00", s_prdata, s_pslverr, {exp_rd1, 32'h1234_5678});
                end
                s_psel = 2'b00;
            end
        end
        exp_rd0 = 32'h1234_5678;
        model_last = 1'b0;
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rand_txn(0));
            q1.push_back(rand_txn(0));
        end
        engine(300, 0, 0, 3, 1'b0);
        tests_run++;
        if (glog.size() != 6) begin
            tests_failed++;
            $display("FAIL fairness_count: got %0d grants required 6", glog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (glog[i] !== 1'(i % 2)) begin
                    tests_failed++;
                    $display("FAIL fairness_order: grant %0d got hart %0d required %0d", i, glog[i], i % 2);
                    break;
                end
            end
        end
    endtask

    task automatic test_misaligned();
        txn_t t;
        t = rand_txn(0); t.addr = 16'h0006; t.wr = 1'b1; q1.push_back(t);
        engine(50, 0, 1, 1, 1'b0);
    endtask

    task automatic test_timeout();
        txn_t t;
        t = rand_txn(0); t.addr = 16'h0020; t.wr = 1'b0; q0.push_back(t);
        engine(100, 0, 1000, 1000, 1'b0);
        t = rand_txn(0); t.addr = 16'h0024; q1.push_back(t);
        engine(50, 0, 1, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 15; i++) begin
            q0.push_back(rand_txn(20));
            q1.push_back(rand_txn(20));
        end
        engine(3000, 3, 0, 20, 1'b1);
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        w_cur = 1000;
        @(negedge clk);
        s_psel = 2'b01; s_paddr = {16'h0000, 16'h0030}; s_pwrite = 2'b00;
        repeat (3) begin
            @(negedge clk);
            timer_drive();
        end
        tests_run++;
        if (!(m_psel === 1'b1 && m_penable === 1'b1)) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got psel %b pen %b required 1 1", m_psel, m_penable);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_phartid, m_pd_pc, s_prdata, s_pready, s_pslverr} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got psel %b pen %b addr %h rdy %b, required all zero", m_psel, m_penable, m_paddr, s_pready);
        end
        s_psel = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            tests_run++;
            if (s_pready !== 2'b00 || m_psel !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_no_pready c=%0d: got rdy %b psel %b required 00 0", c, s_pready, m_psel);
            end
        end
        model_last = 1'b1; exp_rd0 = 32'd0; exp_rd1 = 32'd0; acc_idx = 0;
        q0.push_back(rand_txn(0));
        q1.push_back(rand_txn(0));
        engine(100, 0, 1, 2, 1'b0);
        tests_run++;
        if (glog.size() == 0 || glog[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_first_grant: got %0d grants first %0d required hart 0 first",
                     glog.size(), (glog.size() > 0) ? int'(glog[0]) : -1);
        end
    endtask

    initial begin
        s_psel = 2'b00; s_penable = 2'b00; s_paddr = 32'd0; s_pwrite = 2'b00;
        s_pwdata = 64'd0; s_pc = 64'd0;
        m_pready = 1'b0; m_prdata = 32'd0; m_pslverr = 1'b0;
        test_reset();
        test_contention();
        test_single_read();
        test_fairness();
        test_misaligned();
        test_timeout();
        test_random();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
